// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: the operand is split into STAGES chunks,
// each chunk ripples within one stage and the carry is registered into the next.
module pipelined_rca_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;

  // Bit-serial full-adder cells so the chunk stays a true ripple chain.
  function automatic logic [CHUNK:0] ripple(input logic [CHUNK-1:0] x,
                                            input logic [CHUNK-1:0] y,
                                            input logic             ci);
    logic [CHUNK-1:0] s;
    logic             c;
    c = ci;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] res_q   [STAGES];
  logic [WIDTH-1:0] res_d   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];

  // Index k holds what feeds stage k: the ports for k=0, stage k-1 registers otherwise.
  logic             src_v   [STAGES+1];
  logic             src_c   [STAGES+1];
  logic [WIDTH-1:0] src_a   [STAGES+1];
  logic [WIDTH-1:0] src_b   [STAGES+1];
  logic [WIDTH-1:0] src_res [STAGES+1];
  logic [CHUNK:0]   rip     [STAGES];
  logic             adv;

  assign out_valid = valid_q[STAGES-1] && !rst;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  always_comb begin
    src_v[0]   = in_valid;
    src_c[0]   = sub ? 1'b1 : cin;
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_res[0] = '0;
    for (int k = 0; k < STAGES; k++) begin
      src_v[k+1]   = valid_q[k];
      src_c[k+1]   = carry_q[k];
      src_a[k+1]   = a_q[k];
      src_b[k+1]   = b_q[k];
      src_res[k+1] = res_q[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      rip[k]     = ripple(src_a[k][k*CHUNK +: CHUNK], src_b[k][k*CHUNK +: CHUNK], src_c[k]);
      res_d[k]   = src_res[k];
      res_d[k][k*CHUNK +: CHUNK] = rip[k][CHUNK-1:0];
      carry_d[k] = rip[k][CHUNK];
      a_d[k]     = src_a[k];
      b_d[k]     = src_b[k];
      valid_d[k] = src_v[k];
    end
  end

  // A stall freezes every stage, partial sums and carries included.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '{default: 1'b0};
      carry_q <= '{default: 1'b0};
      res_q   <= '{default: '0};
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign sum  = res_q[STAGES-1];
  assign cout = carry_q[STAGES-1];
  assign ovf  = (a_q[STAGES-1][MSB] == b_q[STAGES-1][MSB]) &&
                (res_q[STAGES-1][MSB] != a_q[STAGES-1][MSB]);

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench: directed and random traffic on a 32/4 instance plus a
// fixed-latency sweep over 8/1, 16/2 and 64/8 instances.
module tb_pipelined_rca_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  logic        sv, sc, ss;
  logic [63:0] sa, sb;
  logic        rdy8, ov8, co8, of8, rdy16, ov16, co16, of16, rdy64, ov64, co64, of64;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [63:0] s64;

  pipelined_rca_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  pipelined_rca_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(sv), .in_ready(rdy8), .a(sa[7:0]), .b(sb[7:0]),
    .cin(sc), .sub(ss), .out_valid(ov8), .out_ready(1'b1),
    .sum(s8), .cout(co8), .ovf(of8));

  pipelined_rca_adder #(.WIDTH(16), .STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(sv), .in_ready(rdy16), .a(sa[15:0]), .b(sb[15:0]),
    .cin(sc), .sub(ss), .out_valid(ov16), .out_ready(1'b1),
    .sum(s16), .cout(co16), .ovf(of16));

  pipelined_rca_adder #(.WIDTH(64), .STAGES(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(sv), .in_ready(rdy64), .a(sa), .b(sb),
    .cin(sc), .sub(ss), .out_valid(ov64), .out_ready(1'b1),
    .sum(s64), .cout(co64), .ovf(of64));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic at width w; returns {ovf, cout, sum[63:0]}.
  function automatic logic [65:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic sb_, input int w);
    logic [64:0] m, xm, ym, full;
    logic [63:0] s;
    logic        co, ov;
    m    = (65'd1 << w) - 65'd1;
    xm   = {1'b0, x} & m;
    ym   = (sb_ ? ~{1'b0, y} : {1'b0, y}) & m;
    full = xm + ym + (sb_ ? 65'd1 : {64'd0, ci});
    s    = full[63:0] & m[63:0];
    co   = full[w];
    ov   = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
    return {ov, co, s};
  endfunction

  // Main-instance scoreboard: in-order queue of expected results and accept cycles.
  logic [65:0] exp_q [$];
  int          acq   [$];
  bit          mon_en = 0, lat_chk = 0, hold_pend = 0, bp_mode = 0, sw_en = 0;
  logic [65:0] held;
  bit          p_has;
  logic [65:0] p_exp;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      logic [65:0] got;
      int          t;
      got = {ovf, cout, 32'd0, sum};
      if (out_valid) begin
        if (hold_pend) chk("hold_stable", got, held);
        if (out_ready) begin
          hold_pend = 0;
          if (exp_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
          else begin
            chk("result", got, exp_q.pop_front());
            t = acq.pop_front();
            if (lat_chk) chk("latency", cyc - t, 4);
          end
        end else begin
          hold_pend = 1;
          held      = got;
        end
      end else if (hold_pend) begin
        chk("valid_dropped", out_valid, 1'b1);
        hold_pend = 0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(p_has ? p_exp : ref_add({32'd0, a}, {32'd0, b}, cin, sub, 32));
        acq.push_back(cyc);
      end
    end
  end

  // Sweep instances never stall, so each result is due exactly STAGES cycles after accept.
  logic [66:0] slot [3][16];

  task automatic sweep_slot(input int i, input logic ov, input logic [65:0] got,
                            input logic rdy, input int w, input int s);
    int n;
    n = cyc % 16;
    chk($sformatf("sweep%0d_valid", w), ov, slot[i][n][66]);
    if (slot[i][n][66]) chk($sformatf("sweep%0d_result", w), got, slot[i][n][65:0]);
    slot[i][n] = '0;
    if (sv && rdy) slot[i][(cyc + s) % 16] = {1'b1, ref_add(sa, sb, sc, ss, w)};
  endtask

  always @(negedge clk) begin
    if (sw_en && !rst) begin
      sweep_slot(0, ov8,  {of8,  co8,  56'd0, s8},  rdy8,  8,  1);
      sweep_slot(1, ov16, {of16, co16, 48'd0, s16}, rdy16, 16, 2);
      sweep_slot(2, ov64, {of64, co64, s64},        rdy64, 64, 8);
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xc,
                      input logic xs, input bit has, input logic [65:0] e);
    int g;
    p_has = has;
    p_exp = e;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      g++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
  endtask

  task automatic send_rand();
    logic [31:0] ra, rb;
    ra = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
    rb = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
    send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 32'h1234_5678; b = 32'h0F0F_0F0F; cin = 1'b1; sub = 1'b0;
    sv = 1'b0; sa = '0; sb = '0; sc = 1'b0; ss = 1'b0;
    p_has = 0; p_exp = '0; held = '0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 16; j++) slot[i][j] = '0;

    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_outputs", {ovf, cout, sum}, 34'd0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    chk("release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("release_in_ready", in_ready, 1'b1);
    chk("release_out_valid", out_valid, 1'b0);
    mon_en = 1;

    lat_chk = 1;
    send(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 66'd0);
    send(32'd1, 32'd2, 1'b1, 1'b0, 1'b1, {2'b00, 64'd4});
    drain();

    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, {2'b01, 64'hFFFF_FFFF});
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, {2'b01, 64'h0});
    drain();

    send(32'd5, 32'd7, 1'b0, 1'b1, 1'b1, {2'b00, 64'hFFFF_FFFE});
    send(32'd7, 32'd5, 1'b1, 1'b1, 1'b1, {2'b01, 64'h2});
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, {2'b10, 64'h8000_0000});
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1, {2'b11, 64'h7FFF_FFFF});
    drain();

    lat_chk = 0;
    bp_mode = 1;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    drain();
    bp_mode = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    repeat (3) send_rand();
    rst = 1'b1;
    exp_q.delete();
    acq.delete();
    hold_pend = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) begin
      chk("no_out_after_rst", out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    lat_chk = 1;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, {2'b00, 64'h100});
    send_rand();
    drain();
    lat_chk = 0;

    sw_en = 1;
    repeat (80) begin
      sv = 1'($urandom_range(0, 3) != 0);
      sa = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      sb = ($urandom_range(0, 4) == 0) ? 64'h0 : {$urandom, $urandom};
      sc = 1'($urandom_range(0, 1));
      ss = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    sv = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    sw_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. It is the next generation of the team's 32-bit combinational RCA.
- The operand width is split into STAGES equal chunks. Each chunk ripples within one cycle, and carries are registered between stages, giving one result per cycle at STAGES latency.
- Adds a subtract mode, a signed-overflow flag and valid/ready flow control so it can sit directly in datapath pipelines.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be ≥ 2.
- STAGES, 4, number of pipeline stages. Must be ≥ 1 and divide WIDTH exactly. CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands on a, b, cin, sub are valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Used only when sub=0.
- sub  input  1  0: a+b+cin. 1: a-b, computed as a+~b+1; cin is ignored.
- out_valid  output  1  sum, cout and ovf are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. For subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst=1 at a rising edge) clears all stage valid bits, sum, cout and ovf to 0, and discards in-flight operations. While rst=1, out_valid=0. The cycle after rst deasserts, in_ready=1.
- Advance condition: adv = !out_valid || out_ready. When adv=1, every stage shifts by one. When adv=0, every stage holds, including partial sums and carries.
- Input handshake: in_ready = adv. An operation is accepted when in_valid && in_ready.
- Bubbles: when adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Output handshake: a result transfers when out_valid && out_ready. out_valid stays high and sum/cout/ovf stay stable until that transfer happens.
- Operand preparation in stage 0:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - Stage 0 adds chunk 0 (bits CHUNK-1:0) of a and b_eff with c0.
- Stage k (k ≥ 1) adds chunk k of the delayed operands with the registered carry from stage k-1.
  - Upper operand chunks travel in skew registers alongside the pipeline.
  - Completed low chunks are carried forward in the result registers.
- Each chunk is a true ripple chain of full-adder cells. No lookahead; synthesis must not fold it into a single wide adder.
- Latency: exactly STAGES cycles from acceptance to out_valid, provided adv stays 1 throughout.
- Throughput: 1 result per cycle with out_ready held at 1.
- STAGES=1: degenerates to a single registered WIDTH-bit RCA with latency 1.
- cout = carry out of bit WIDTH-1.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- sum wraps modulo 2^WIDTH; no saturation.
- Simultaneous accept and drain in the same cycle are allowed, with no bubble inserted.
- in_valid, a, b, cin and sub are ignored while in_ready=0. Upstream must hold them until accepted.
- Stalls never drop, duplicate or reorder results. Results leave in acceptance order.
- Pipeline occupancy never exceeds STAGES; no extra buffering.
- Reset mid-operation: in-flight results are lost. No spurious out_valid follows the reset.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, sum=0, cout=0, ovf=0 throughout; in_ready=1 the cycle after release.
- Basic add: a=0,b=0,cin=0 then a=1,b=2,cin=1, out_ready=1 → results 0 then 4, each arriving exactly 4 cycles after acceptance, on consecutive cycles; cout=0, ovf=0.
- Carry ripple across all stage boundaries: a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 → sum=0xFFFFFFFF, cout=1, ovf=0. Also a=0xFFFFFFFF, b=0, cin=1 → sum=0, cout=1.
- Subtract and overflow:
  - sub=1, a=5, b=7 → sum=0xFFFFFFFE, cout=0.
  - sub=1, a=7, b=5 → sum=2, cout=1.
  - sub=0, a=0x7FFFFFFF, b=1 → sum=0x80000000, ovf=1.
  - sub=1, a=0x80000000, b=1 → sum=0x7FFFFFFF, ovf=1.
- Backpressure: stream 20 random operations with out_ready toggling randomly → every result matches the reference model in order, with no loss or duplication, and sum/cout/ovf stay stable while out_valid && !out_ready.
- Reset mid-flight and parameter sweep:
  - Assert rst with 3 operations in flight → no out_valid afterwards until new input is accepted.
  - Repeat the random stream for (WIDTH,STAGES) = (8,1), (16,2) and (64,8) → correct results at latency STAGES.
